// File: rtl/cpu_types_pkg.sv
// Shared types for the unified-RAM arbiter: bus word, arbiter state, abort pattern.
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} arb_state_t;

   localparam word_t BAD_WORD       = 32'hBAD1BAD1;
   localparam int    STARVE_MAX_DEF = 4;
   localparam int    TIMEOUT_DEF    = 15;
endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Fetch/data request ports and RAM port of the arbiter, bundled as one interface.
interface mem_arbiter_ctrl_if;
   import cpu_types_pkg::*;

   logic  iREN, iwait, dREN, dWEN, dwait;
   logic  ram_ren, ram_wen, ram_rdy, err;
   word_t iaddr, iload, daddr, dstore, dload;
   word_t ram_addr, ram_store, ram_load;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_rdy,
      output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_rdy,
      input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store, err
   );
endinterface

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts cycles spent in an access state; expired marks the last
// cycle an access may wait for ram_rdy before it is aborted.
module mem_arb_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && cnt != W'(TIMEOUT))
         cnt <= cnt + 1'b1;
   end

   // cnt holds the cycles already waited, so the TIMEOUT-th waiting cycle sees TIMEOUT-1
   assign expired = enable && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Single-port RAM sequencer between instruction fetch and data ports. Data wins
// ties unless fetch has been passed over STARVE_MAX times in a row.
module mem_arbiter_ctrl
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input logic              CLK,
   input logic              RST,
   mem_arbiter_ctrl_if.slave bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_t    state, state_n;
   logic [SW-1:0] starve, starve_n;
   logic          ren_n, wen_n, err_n;
   word_t         addr_n, store_n, iload_n, dload_n;
   logic          d_req, starved, in_acc, t_expired;

   assign d_req   = bus.dREN | bus.dWEN;
   assign starved = bus.iREN && (starve == SW'(STARVE_MAX));
   assign in_acc  = (state == IACC) || (state == DACC);

   mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .CLK     (CLK),
      .RST     (RST),
      .clear   (!in_acc),
      .enable  (in_acc),
      .expired (t_expired)
   );

   // Waits follow the live request levels; only the response cycle releases them
   assign bus.iwait = bus.iREN & (state != IRESP);
   assign bus.dwait = d_req & (state != DRESP);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= IDLE;
         starve        <= '0;
         bus.ram_ren   <= 1'b0;
         bus.ram_wen   <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_store <= '0;
         bus.iload     <= '0;
         bus.dload     <= '0;
         bus.err       <= 1'b0;
      end else begin
         state         <= state_n;
         starve        <= starve_n;
         bus.ram_ren   <= ren_n;
         bus.ram_wen   <= wen_n;
         bus.ram_addr  <= addr_n;
         bus.ram_store <= store_n;
         bus.iload     <= iload_n;
         bus.dload     <= dload_n;
         bus.err       <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      starve_n = starve;
      ren_n    = bus.ram_ren;
      wen_n    = bus.ram_wen;
      addr_n   = bus.ram_addr;
      store_n  = bus.ram_store;
      iload_n  = bus.iload;
      dload_n  = bus.dload;
      err_n    = bus.err;
      unique case (state)
         IDLE: begin
            if (!bus.iREN)
               starve_n = '0;
            if (d_req && !starved) begin
               state_n = DACC;
               addr_n  = bus.daddr;
               store_n = bus.dstore;
               wen_n   = bus.dWEN;
               ren_n   = !bus.dWEN;
               // starved is false here, so starve < STARVE_MAX and cannot wrap
               if (bus.iREN)
                  starve_n = starve + 1'b1;
            end else if (bus.iREN) begin
               state_n  = IACC;
               addr_n   = bus.iaddr;
               ren_n    = 1'b1;
               starve_n = '0;
            end
         end
         IACC: begin
            if (bus.ram_rdy) begin
               iload_n = bus.ram_load;
               ren_n   = 1'b0;
               state_n = IRESP;
            end else if (t_expired) begin
               err_n   = 1'b1;
               iload_n = BAD_WORD;
               ren_n   = 1'b0;
               state_n = IRESP;
            end
         end
         DACC: begin
            if (bus.ram_rdy) begin
               if (!bus.ram_wen)
                  dload_n = bus.ram_load;
               ren_n   = 1'b0;
               wen_n   = 1'b0;
               state_n = DRESP;
            end else if (t_expired) begin
               err_n   = 1'b1;
               dload_n = BAD_WORD;
               ren_n   = 1'b0;
               wen_n   = 1'b0;
               state_n = DRESP;
            end
         end
         IRESP, DRESP: state_n = IDLE;
         default:      state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Randomized + directed bench: RAM responder model, transaction-level grant model
// and response scoreboards fed by the requester tasks.
module tb_mem_arbiter_ctrl;
   import cpu_types_pkg::*;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 15;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   mem_arbiter_ctrl_if b ();

   mem_arbiter_ctrl #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (b)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic  wr;
      word_t data;
   } dexp_t;

   word_t iq[$];
   dexp_t dq[$];
   word_t ram_mem[word_t];
   word_t ref_mem[word_t];
   int    gkinds[$];

   int vectors    = 0;
   int miscompares = 0;
   int rdy_delay  = 0;
   bit spurious   = 1'b0;

   // grant-order model state
   int    starve_m = 0, strobe_len = 0, last_len = 0, gap = 99, i_resp_cnt = 0;
   bit    prev_strobe = 0, prev_iren = 0, prev_dreq = 0, prev_dwen = 0;
   bit    strobe, gi, ei;
   word_t prev_iaddr = '0, prev_daddr = '0, prev_dstore = '0;
   dexp_t de;

   function automatic word_t init_word(word_t a);
      if (a == 32'h40) return 32'h8C220004;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic word_t ram_rd(word_t a);
      return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
   endfunction

   function automatic word_t ref_rd(word_t a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic check(string name, word_t act, word_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got no/extra event expected none/one", name);
   endtask

   // RAM: ready after a (possibly random) number of strobe cycles; writes commit on ready
   initial begin
      int cnt, cur;
      cnt = 0; cur = 0;
      b.ram_rdy  = 1'b0;
      b.ram_load = '0;
      forever begin
         @(posedge CLK);
         #1;
         if (RST) begin
            b.ram_rdy = 1'b0;
            cnt = 0;
         end else if (b.ram_ren || b.ram_wen) begin
            if (cnt == 0) cur = (rdy_delay < 0) ? int'($urandom_range(0, 3)) : rdy_delay;
            if (cnt >= cur) begin
               b.ram_rdy  = 1'b1;
               b.ram_load = ram_rd(b.ram_addr);
               if (b.ram_wen) ram_mem[b.ram_addr] = b.ram_store;
            end else begin
               b.ram_rdy  = 1'b0;
               b.ram_load = $urandom;
            end
            cnt++;
         end else begin
            cnt = 0;
            b.ram_rdy  = spurious && ($urandom_range(0, 3) == 0);
            b.ram_load = $urandom;
         end
      end
   end

   // Monitor: response scoreboards and grant-order model
   always @(negedge CLK) begin
      if (RST) begin
         starve_m    = 0;
         prev_strobe = 0;
         strobe_len  = 0;
         gap         = 99;
      end else begin
         strobe = b.ram_ren | b.ram_wen;
         if (b.iREN && !b.iwait) begin
            i_resp_cnt++;
            if (iq.size() == 0) fail("i_spurious_resp");
            else check("iload", b.iload, iq.pop_front());
         end
         if ((b.dREN || b.dWEN) && !b.dwait) begin
            if (dq.size() == 0) fail("d_spurious_resp");
            else begin
               de = dq.pop_front();
               check("d_kind", 32'(b.dWEN), 32'(de.wr));
               if (!de.wr) check("dload", b.dload, de.data);
            end
         end
         if (strobe && !prev_strobe) begin
            gi = (b.ram_addr < 32'h100);
            ei = prev_iren && (!prev_dreq || starve_m == STARVE_MAX);
            check("grant_gap", 32'(gap >= 2), 32'd1);
            check("grant_kind", 32'(gi), 32'(ei));
            gkinds.push_back(int'(gi));
            if (ei) begin
               check("i_addr", b.ram_addr, prev_iaddr);
               check("i_strobe", 32'({b.ram_wen, b.ram_ren}), 32'd1);
               starve_m = 0;
            end else begin
               check("d_addr", b.ram_addr, prev_daddr);
               check("d_strobe", 32'({b.ram_wen, b.ram_ren}), prev_dwen ? 32'd2 : 32'd1);
               if (prev_dwen) check("d_store", b.ram_store, prev_dstore);
               starve_m = !prev_iren ? 0 : (starve_m >= STARVE_MAX ? STARVE_MAX : starve_m + 1);
            end
            strobe_len = 0;
         end
         if (strobe) begin
            strobe_len++;
            gap = 0;
         end else begin
            if (prev_strobe) last_len = strobe_len;
            gap++;
         end
         prev_strobe = strobe;
         prev_iren   = b.iREN;
         prev_dreq   = b.dREN | b.dWEN;
         prev_dwen   = b.dWEN;
         prev_iaddr  = b.iaddr;
         prev_daddr  = b.daddr;
         prev_dstore = b.dstore;
      end
   end

   task automatic ireq(word_t a);
      @(posedge CLK); #1;
      b.iREN  = 1'b1;
      b.iaddr = a;
      iq.push_back(ref_rd(a));
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (b.iREN && !b.iwait) return;
      end
      fail("i_resp_timeout");
   endtask

   task automatic i_drop();
      @(posedge CLK); #1;
      b.iREN  = 1'b0;
      b.iaddr = $urandom;
   endtask

   task automatic dreq(bit ren, bit wen, word_t a, word_t d, bit expect_bad);
      @(posedge CLK); #1;
      b.dREN   = ren;
      b.dWEN   = wen;
      b.daddr  = a;
      b.dstore = d;
      if (wen) begin
         dq.push_back('{1'b1, d});
         ref_mem[a] = d;
      end else
         dq.push_back('{1'b0, expect_bad ? BAD_WORD : ref_rd(a)});
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if ((b.dREN || b.dWEN) && !b.dwait) return;
      end
      fail("d_resp_timeout");
   endtask

   task automatic d_drop();
      @(posedge CLK); #1;
      b.dREN = 1'b0;
      b.dWEN = 1'b0;
   endtask

   initial begin
      b.iREN = 1'b0; b.iaddr = '0; b.dREN = 1'b0; b.dWEN = 1'b0; b.daddr = '0; b.dstore = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_ren",   32'(b.ram_ren), 32'd0);
      check("rst_wen",   32'(b.ram_wen), 32'd0);
      check("rst_err",   32'(b.err),     32'd0);
      check("rst_addr",  b.ram_addr,     32'd0);
      check("rst_store", b.ram_store,    32'd0);
      check("rst_iload", b.iload,        32'd0);
      check("rst_dload", b.dload,        32'd0);
      RST = 1'b0;

      // single fetch, ready two cycles after the strobe
      rdy_delay = 1; i_resp_cnt = 0;
      ireq(32'h40);
      i_drop();
      check("t1_ren_cycles", 32'(last_len), 32'd2);
      check("t1_resp_cycles", 32'(i_resp_cnt), 32'd1);
      check("t1_iload", b.iload, 32'h8C220004);

      // simultaneous fetch and write: write first
      rdy_delay = 0; gkinds.delete();
      fork
         begin ireq(32'h44); i_drop(); end
         begin dreq(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0); d_drop(); end
      join
      if (gkinds.size() < 2) fail("t2_grant_count");
      else begin
         check("t2_first_data",  32'(gkinds[0]), 32'd0);
         check("t2_second_inst", 32'(gkinds[1]), 32'd1);
      end
      dreq(1'b1, 1'b0, 32'h100, '0, 1'b0);
      d_drop();

      // starvation: four data grants, then the held fetch
      gkinds.delete();
      fork
         begin ireq(32'h48); i_drop(); end
         begin
            for (int k = 0; k < 6; k++) dreq(1'b1, 1'b0, 32'h100 + 32'(4 * k), '0, 1'b0);
            d_drop();
         end
      join
      if (gkinds.size() < 6) fail("t3_grant_count");
      else begin
         for (int k = 0; k < 4; k++) check("t3_data_grant", 32'(gkinds[k]), 32'd0);
         check("t3_forced_inst", 32'(gkinds[4]), 32'd1);
         check("t3_data_after",  32'(gkinds[5]), 32'd0);
      end

      // watchdog abort
      rdy_delay = 1000;
      dreq(1'b1, 1'b0, 32'h120, '0, 1'b1);
      d_drop();
      check("t4_strobe_cycles", 32'(last_len), 32'(TIMEOUT));
      check("t4_err", 32'(b.err), 32'd1);
      check("t4_dload", b.dload, BAD_WORD);
      rdy_delay = 0;
      ireq(32'h4C); i_drop();
      dreq(1'b0, 1'b1, 32'h104, 32'h0BADCAFE, 1'b0); d_drop();
      check("t4_err_sticky", 32'(b.err), 32'd1);

      // async reset during a write access
      rdy_delay = 1000;
      @(posedge CLK); #1;
      b.dREN = 1'b1; b.dWEN = 1'b1; b.daddr = 32'h140; b.dstore = 32'h12345678;
      repeat (3) @(posedge CLK);
      #2;
      check("t5_wen_before", 32'(b.ram_wen), 32'd1);
      RST = 1'b1;
      #1;
      check("t5_wen_async", 32'(b.ram_wen), 32'd0);
      check("t5_dwait_held", 32'(b.dwait), 32'd1);
      check("t5_err_clear", 32'(b.err), 32'd0);
      @(posedge CLK); #1;
      b.dREN = 1'b0; b.dWEN = 1'b0;
      RST = 1'b0;
      rdy_delay = 0;

      // data request withdrawn mid-access: access still runs to ready
      rdy_delay = 3;
      @(posedge CLK); #1;
      b.dREN = 1'b1; b.daddr = 32'h180;
      repeat (2) @(posedge CLK);
      #1;
      b.dREN = 1'b0;
      repeat (6) @(negedge CLK);
      check("t6_strobe_cycles", 32'(last_len), 32'd4);
      check("t6_no_d_expect", 32'(dq.size()), 32'd0);
      rdy_delay = 0;
      ireq(32'h50); i_drop();

      // randomized traffic with random latencies and stray ready pulses
      rdy_delay = -1; spurious = 1'b1;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               int g;
               ireq(32'(4 * $urandom_range(0, 63)));
               g = $urandom_range(0, 2);
               if (g > 0) begin i_drop(); repeat (g - 1) @(posedge CLK); end
            end
            i_drop();
         end
         begin
            for (int k = 0; k < 40; k++) begin
               int op, g;
               op = $urandom_range(0, 2);
               dreq(op != 1, op != 0, 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, 1'b0);
               g = $urandom_range(0, 2);
               if (g > 0) begin d_drop(); repeat (g - 1) @(posedge CLK); end
            end
            d_drop();
         end
      join
      repeat (5) @(posedge CLK);
      check("sb_i_drained", 32'(iq.size()), 32'd0);
      check("sb_d_drained", 32'(dq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
